afe_emulator: RTL and testbench



---
 rtl/afe_pkg.sv | 33 +++
 rtl/afe_pulse_gen.sv | 35 +++
 rtl/afe_emulator.sv | 129 ++++++++++++
 tb/tb_afe_emulator.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/afe_pkg.sv
// afe_pkg: shared constants, state encoding and the input bundle
// for the analog front-end emulator.
package afe_pkg;

    localparam int STEP_DIV_DEF    = 16;
    localparam int SETTLE_CYC_DEF  = 8;
    localparam int CONV_CYC_DEF    = 4;
    localparam int DC_GAIN_IR_DEF  = 12;
    localparam int DC_GAIN_RED_DEF = 8;
    localparam int COMP_LSB_DEF    = 2;
    localparam int AMBIENT_DEF     = 4;

    typedef enum logic {
        ST_SETTLE  = 1'b0,
        ST_CONVERT = 1'b1
    } afe_state_e;

    typedef struct packed {
        logic [3:0] drive;
        logic [6:0] dc_comp;
        logic       ir;
        logic       red;
        logic [3:0] gain;
    } afe_in_t;

    // Triangle over a 64-step beat: rises 0..31 then falls 31..0.
    function automatic logic [4:0] pulse_tri(input logic [5:0] idx);
        logic [5:0] t;
        t = idx[5] ? (6'd63 - idx) : idx;
        return t[4:0];
    endfunction

endpackage

// File: rtl/afe_pulse_gen.sv
// afe_pulse_gen: heartbeat index generator; one index step every
// STEP_DIV clocks, triangle-shaped pulse amplitude out.
module afe_pulse_gen
    import afe_pkg::*;
#(
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [5:0] idx_o,
    output logic [4:0] pulse_o
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [5:0]    idx_q;

    // Free-running prescaler; the beat index advances on each wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PW'(STEP_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= idx_q + 6'd1;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign idx_o   = idx_q;
    assign pulse_o = pulse_tri(idx_q);

endmodule

// File: rtl/afe_emulator.sv
// afe_emulator: photodiode + DC-comp DAC + PGA + 8-bit ADC model
// returning a synthetic heartbeat to the Controller.
module afe_emulator
    import afe_pkg::*;
#(
    parameter int STEP_DIV    = STEP_DIV_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int CONV_CYC    = CONV_CYC_DEF,
    parameter int DC_GAIN_IR  = DC_GAIN_IR_DEF,
    parameter int DC_GAIN_RED = DC_GAIN_RED_DEF,
    parameter int COMP_LSB    = COMP_LSB_DEF,
    parameter int AMBIENT     = AMBIENT_DEF
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic [3:0] LED_DRIVE,
    input  logic [6:0] DC_Comp,
    input  logic       LED_IR,
    input  logic       LED_RED,
    input  logic [3:0] PGA_Gain,
    output logic [7:0] ADC,
    output logic       ADC_valid,
    output logic       Fault,
    output logic [5:0] Pulse_idx
);

    localparam int CMAX = (SETTLE_CYC > CONV_CYC) ? SETTLE_CYC : CONV_CYC;
    localparam int CW   = $clog2(CMAX) + 1;

    afe_in_t    live;
    afe_in_t    snap_q;
    afe_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic [4:0] pulse_hold_q;
    logic [7:0] adc_q;
    logic       adc_valid_q;

    logic [4:0] pulse;

    logic [9:0]  drv;
    logic [9:0]  pls;
    logic [9:0]  prod;
    logic [9:0]  photo;
    logic [9:0]  comp;
    logic [9:0]  diff;
    logic [13:0] gain;
    logic [13:0] amp;
    logic [7:0]  adc_d;

    assign live = {LED_DRIVE, DC_Comp, LED_IR, LED_RED, PGA_Gain};

    afe_pulse_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_pulse (
        .clk_i   (CLK),
        .rst_ni  (rst_n),
        .idx_o   (Pulse_idx),
        .pulse_o (pulse)
    );

    // Photocurrent, DC compensation, PGA and ADC clip from the snapshot.
    always_comb begin
        drv  = {6'd0, snap_q.drive};
        pls  = {5'd0, pulse_hold_q};
        prod = pls * drv;
        photo = 10'(AMBIENT);
        if (snap_q.ir && !snap_q.red) begin
            photo = 10'(AMBIENT) + drv * 10'(DC_GAIN_IR) + (prod >> 2);
        end else if (snap_q.red && !snap_q.ir) begin
            photo = 10'(AMBIENT) + drv * 10'(DC_GAIN_RED) + (prod >> 3);
        end
        comp = {3'd0, snap_q.dc_comp} * 10'(COMP_LSB);
        diff = (photo > comp) ? (photo - comp) : 10'd0;
        gain = {10'd0, snap_q.gain} + 14'd1;
        amp  = {4'd0, diff} * gain;
        if (snap_q.ir && snap_q.red) begin
            adc_d = 8'hFF;
        end else if (amp > 14'd255) begin
            adc_d = 8'hFF;
        end else begin
            adc_d = amp[7:0];
        end
    end

    // Settle/convert sequencer; any input change restarts settling.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            snap_q       <= '0;
            state_q      <= ST_SETTLE;
            cnt_q        <= '0;
            pulse_hold_q <= '0;
            adc_q        <= '0;
            adc_valid_q  <= 1'b0;
        end else begin
            adc_valid_q <= 1'b0;
            if (live != snap_q) begin
                snap_q  <= live;
                state_q <= ST_SETTLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_SETTLE: begin
                        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                            pulse_hold_q <= pulse;
                            state_q      <= ST_CONVERT;
                            cnt_q        <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_CONVERT: begin
                        if (cnt_q == CW'(CONV_CYC - 1)) begin
                            adc_q       <= adc_d;
                            adc_valid_q <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign ADC       = adc_q;
    assign ADC_valid = adc_valid_q;
    assign Fault     = snap_q.ir & snap_q.red;

endmodule

// File: tb/tb_afe_emulator.sv
// tb_afe_emulator: directed checks of the AFE emulator timing,
// arithmetic, saturation, fault and abort behaviour.
`timescale 1ns/1ps
module tb_afe_emulator;

    logic       CLK;
    logic       rst_n;
    logic [3:0] LED_DRIVE;
    logic [6:0] DC_Comp;
    logic       LED_IR;
    logic       LED_RED;
    logic [3:0] PGA_Gain;
    logic [7:0] ADC;
    logic       ADC_valid;
    logic       Fault;
    logic [5:0] Pulse_idx;

    int n_cmp = 0;
    int n_mis = 0;

    afe_emulator dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .LED_DRIVE (LED_DRIVE),
        .DC_Comp   (DC_Comp),
        .LED_IR    (LED_IR),
        .LED_RED   (LED_RED),
        .PGA_Gain  (PGA_Gain),
        .ADC       (ADC),
        .ADC_valid (ADC_valid),
        .Fault     (Fault),
        .Pulse_idx (Pulse_idx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input logic [3:0] d, input logic [6:0] c,
                            input logic ir, input logic red,
                            input logic [3:0] g);
        LED_DRIVE = d;
        DC_Comp   = c;
        LED_IR    = ir;
        LED_RED   = red;
        PGA_Gain  = g;
    endtask

    // Edges until ADC_valid is seen; -1 if the budget expires.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (ADC_valid) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int nv;
        rst_n = 1'b0;
        drive_in(4'd0, 7'd0, 1'b0, 1'b0, 4'd0);
        repeat (3) @(negedge CLK);
        chk("rst_adc", 32'(ADC), 32'd0);
        chk("rst_valid", 32'(ADC_valid), 32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);
        chk("rst_idx", 32'(Pulse_idx), 32'd0);

        // LEDs off: ambient only
        rst_n = 1'b1;
        wait_valid(n);
        chk("off_lat", 32'(n), 32'd12);
        chk("off_adc", 32'(ADC), 32'd4);
        wait_valid(n);
        chk("off_period", 32'(n), 32'd4);
        chk("off_adc2", 32'(ADC), 32'd4);
        chk("idx_wrap", 32'(Pulse_idx), 32'd1);

        // IR drive 10 from reset, pulse 0 at latch
        rst_n = 1'b0;
        drive_in(4'd10, 7'd0, 1'b1, 1'b0, 4'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        wait_valid(n);
        chk("ir_lat", 32'(n), 32'd13);
        chk("ir_adc", 32'(ADC), 32'd124);

        // reset in the middle of a conversion
        repeat (2) @(negedge CLK);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_adc", 32'(ADC), 32'd0);
        chk("mid_rst_valid", 32'(ADC_valid), 32'd0);
        chk("mid_rst_idx", 32'(Pulse_idx), 32'd0);
        drive_in(4'd0, 7'd0, 1'b0, 1'b0, 4'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        wait_valid(n);
        chk("rel_lat", 32'(n), 32'd12);
        chk("rel_adc", 32'(ADC), 32'd4);

        // saturation: drive 15, gain x16
        drive_in(4'd15, 7'd0, 1'b1, 1'b0, 4'd15);
        wait_valid(n);
        chk("sat_lat", 32'(n), 32'd13);
        chk("sat_adc", 32'(ADC), 32'd255);

        // over-compensation clamps to zero
        drive_in(4'd10, 7'd127, 1'b1, 1'b0, 4'd0);
        wait_valid(n);
        chk("clamp_lat", 32'(n), 32'd13);
        chk("clamp_adc", 32'(ADC), 32'd0);

        // both LEDs on
        drive_in(4'd4, 7'd0, 1'b1, 1'b1, 4'd0);
        @(negedge CLK);
        chk("fault_on", 32'(Fault), 32'd1);
        wait_valid(n);
        chk("fault_lat", 32'(n), 32'd12);
        chk("fault_adc", 32'(ADC), 32'd255);

        // clear RED: IR drive 4, pulse 3 at latch -> 4+48+3
        drive_in(4'd4, 7'd0, 1'b1, 1'b0, 4'd0);
        @(negedge CLK);
        chk("fault_off", 32'(Fault), 32'd0);
        wait_valid(n);
        chk("clr_lat", 32'(n), 32'd12);
        chk("clr_adc", 32'(ADC), 32'd55);

        // gain change mid-conversion aborts it
        @(negedge CLK);
        drive_in(4'd4, 7'd0, 1'b1, 1'b0, 4'd2);
        nv = 0;
        repeat (12) begin
            @(negedge CLK);
            if (ADC_valid) nv++;
        end
        chk("abort_nv", 32'(nv), 32'd0);
        chk("abort_hold", 32'(ADC), 32'd55);
        @(negedge CLK);
        chk("gain_valid", 32'(ADC_valid), 32'd1);
        chk("gain_adc", 32'(ADC), 32'd168);

        // RED only: drive 8, pulse 5, gain x3 -> (4+64+5)*3
        drive_in(4'd8, 7'd0, 1'b0, 1'b1, 4'd2);
        wait_valid(n);
        chk("red_lat", 32'(n), 32'd13);
        chk("red_adc", 32'(ADC), 32'd219);
        wait_valid(n);
        chk("red_period", 32'(n), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
